// File: rtl/demux_pkg.sv
// Shared definitions for the 1-to-8 demux dispatcher.
//   NUM_CH / SEL_W : channel count and select width
//   state_e        : IDLE (nothing held) / HOLD (one beat offered)
//   RR / DIRECTED  : encodings of the 'mode' input
package demux_pkg;

  localparam int unsigned NUM_CH = 8;
  localparam int unsigned SEL_W  = 3;

  typedef enum logic {
    IDLE,
    HOLD
  } state_e;

  localparam logic RR       = 1'b0;
  localparam logic DIRECTED = 1'b1;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority picker.
//   mask_i  : candidate channels
//   ptr_i   : last granted channel; search starts at ptr_i+1 and wraps
//   idx_o   : first set mask bit found from ptr_i+1 upward
//   found_o : mask_i has at least one bit set
module rr_pick
  import demux_pkg::*;
(
  input  logic [NUM_CH-1:0] mask_i,
  input  logic [SEL_W-1:0]  ptr_i,
  output logic [SEL_W-1:0]  idx_o,
  output logic              found_o
);

  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      // Offset wraps naturally in SEL_W bits, giving the 7->0 rotation.
      logic [SEL_W-1:0] cand;
      cand = ptr_i + SEL_W'(k + 1);
      if (!found_o && mask_i[cand]) begin
        idx_o   = cand;
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/demux_rr_dispatcher.sv
// Sequencing controller for the 1-to-8 demux datapath: accepts one
// valid/ready stream and steers each beat to a channel, round-robin over
// enabled channels or directed by 'dest'. A one-entry holding register
// sits between the producer and the eight consumers.
//   clk, rst_n           : clock, synchronous active-low reset
//   mode, dest, chan_en  : steering controls, sampled on acceptance
//   in_valid/in_data/in_ready : producer side
//   out_valid (one-hot), out_data, out_ready : consumer side
//   cur_sel              : channel of the held beat (demux select)
//   beat_cnt             : delivered beats, wrapping
//   drop_cnt             : directed beats discarded, saturating at 255
module demux_rr_dispatcher
  import demux_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode,
  input  logic [SEL_W-1:0]  dest,
  input  logic [NUM_CH-1:0] chan_en,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [NUM_CH-1:0] out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic [NUM_CH-1:0] out_ready,
  output logic [SEL_W-1:0]  cur_sel,
  output logic [CNT_W-1:0]  beat_cnt,
  output logic [7:0]        drop_cnt
);

  state_e              state_q, state_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [SEL_W-1:0]    ptr_q, ptr_d;
  logic [NUM_CH-1:0]   ov_q, ov_d;
  logic [CNT_W-1:0]    beat_q, beat_d;
  logic [7:0]          drop_q, drop_d;

  logic [SEL_W-1:0]    pick_idx;
  logic                pick_found;
  logic                deliver;
  logic                accept;
  logic                avail;

  rr_pick u_pick (
    .mask_i  (chan_en),
    .ptr_i   (ptr_q),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  // pick_found is equivalent to chan_en != 0.
  assign avail    = (mode == DIRECTED) || pick_found;
  assign deliver  = (state_q == HOLD) && out_ready[sel_q];
  assign in_ready = rst_n && ((state_q == IDLE) || deliver) && avail;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    data_d  = data_q;
    ptr_d   = ptr_q;
    beat_d  = beat_q;
    drop_d  = drop_q;
    ov_d    = '0;

    if (deliver) begin
      beat_d  = beat_q + CNT_W'(1);
      state_d = IDLE;
    end

    // An accept in the same cycle as a deliver overrides the return to IDLE.
    if (accept) begin
      if (mode == DIRECTED) begin
        if (chan_en[dest]) begin
          state_d = HOLD;
          sel_d   = dest;
          data_d  = in_data;
        end else if (drop_q != '1) begin
          drop_d = drop_q + 8'(1);
        end
      end else begin
        state_d = HOLD;
        sel_d   = pick_idx;
        ptr_d   = pick_idx;
        data_d  = in_data;
      end
    end

    if (state_d == HOLD) begin
      ov_d[sel_d] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      data_q  <= '0;
      ptr_q   <= SEL_W'(NUM_CH - 1);
      ov_q    <= '0;
      beat_q  <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      ptr_q   <= ptr_d;
      ov_q    <= ov_d;
      beat_q  <= beat_d;
      drop_q  <= drop_d;
    end
  end

  assign out_valid = ov_q;
  assign out_data  = data_q;
  assign cur_sel   = sel_q;
  assign beat_cnt  = beat_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_demux_rr_dispatcher.sv
module tb_demux_rr_dispatcher;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mode;
  logic [2:0] dest;
  logic [7:0] chan_en;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [7:0] out_valid;
  logic [7:0] out_data;
  logic [7:0] out_ready;
  logic [2:0] cur_sel;
  logic [15:0] beat_cnt;
  logic [7:0] drop_cnt;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  demux_rr_dispatcher #(.DATA_W(8), .CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .dest      (dest),
    .chan_en   (chan_en),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .cur_sel   (cur_sel),
    .beat_cnt  (beat_cnt),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural reference: one optional held beat plus counters.
  bit          m_held;
  bit          m_fresh;
  int unsigned m_sel;
  int unsigned m_ptr;
  logic [7:0]  m_data;
  int unsigned m_beats;
  int unsigned m_drops;

  task automatic model_reset();
    m_held  = 0;
    m_fresh = 1;
    m_sel   = 0;
    m_ptr   = 7;
    m_data  = 8'h00;
    m_beats = 0;
    m_drops = 0;
  endtask

  function automatic bit exp_ready();
    return rst_n && (!m_held || out_ready[m_sel]) && (mode || (chan_en != 8'h00));
  endfunction

  task automatic model_step();
    bit rdy;
    if (!rst_n) begin
      model_reset();
      return;
    end
    rdy = exp_ready();
    if (m_held && out_ready[m_sel]) begin
      m_beats = (m_beats + 1) % 65536;
      m_held  = 0;
    end
    if (in_valid && rdy) begin
      if (mode) begin
        if (chan_en[dest]) begin
          m_held = 1; m_fresh = 0; m_sel = dest; m_data = in_data;
        end else if (m_drops < 255) begin
          m_drops++;
        end
      end else begin
        for (int j = 1; j <= 8; j++) begin
          int unsigned c;
          c = (m_ptr + j) % 8;
          if (chan_en[c]) begin
            m_held = 1; m_fresh = 0; m_sel = c; m_ptr = c; m_data = in_data;
            break;
          end
        end
      end
    end
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs and compare everything against the model.
  task automatic apply(logic r, logic md, logic [2:0] d, logic [7:0] en,
                       logic v, logic [7:0] dat, logic [7:0] rdy);
    rst_n = r; mode = md; dest = d; chan_en = en;
    in_valid = v; in_data = dat; out_ready = rdy;
    #1;
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ready()});
    chk("out_valid", {24'd0, out_valid}, m_held ? (32'd1 << m_sel) : 32'd0);
    if (m_held || m_fresh) begin
      chk("out_data", {24'd0, out_data}, {24'd0, m_data});
      chk("cur_sel", {29'd0, cur_sel}, m_sel);
    end
    chk("beat_cnt", {16'd0, beat_cnt}, m_beats);
    chk("drop_cnt", {24'd0, drop_cnt}, m_drops);
  endtask

  task automatic advance();
    model_step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        rst;
    logic        md;
    logic [7:0]  en;
    logic        vld;
    logic [7:0]  dat;
    logic [7:0]  rdy;
    logic        exp_rdy;
    logic [7:0]  exp_ov;
    logic [7:0]  exp_data;
    logic [15:0] exp_beat;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic md, logic [7:0] en, logic vld,
                              logic [7:0] dat, logic [7:0] rdy, logic exp_rdy,
                              logic [7:0] exp_ov, logic [7:0] exp_data,
                              logic [15:0] exp_beat);
    vec_t v;
    v.rst = rst; v.md = md; v.en = en; v.vld = vld; v.dat = dat; v.rdy = rdy;
    v.exp_rdy = exp_rdy; v.exp_ov = exp_ov; v.exp_data = exp_data;
    v.exp_beat = exp_beat;
    return v;
  endfunction

  initial begin
    logic [7:0]  held_data;
    logic [15:0] beats_before;

    // Round-robin over all channels: beat k lands on channel k%8,
    // visible the cycle after it is accepted, no bubbles.
    for (int k = 0; k < 10; k++) begin
      tbl.push_back(mk(1, 0, 8'hFF, 1, 8'(k), 8'hFF, 1,
                       (k == 0) ? 8'h00 : 8'(1 << ((k - 1) % 8)),
                       8'(k - 1), (k == 0) ? 16'd0 : 16'(k - 1)));
    end
    tbl.push_back(mk(1, 0, 8'hFF, 0, 8'h00, 8'hFF, 1, 8'h02, 8'h09, 16'd9));
    tbl.push_back(mk(1, 0, 8'hFF, 0, 8'h00, 8'hFF, 1, 8'h00, 8'h00, 16'd10));
    // Reset, then chan_en=0x22 alternates channels 1 and 5.
    tbl.push_back(mk(0, 0, 8'h22, 0, 8'h00, 8'hFF, 0, 8'h00, 8'h00, 16'd10));
    tbl.push_back(mk(1, 0, 8'h22, 1, 8'h10, 8'hFF, 1, 8'h00, 8'h00, 16'd0));
    tbl.push_back(mk(1, 0, 8'h22, 1, 8'h11, 8'hFF, 1, 8'h02, 8'h10, 16'd0));
    tbl.push_back(mk(1, 0, 8'h22, 1, 8'h12, 8'hFF, 1, 8'h20, 8'h11, 16'd1));
    tbl.push_back(mk(1, 0, 8'h22, 1, 8'h13, 8'hFF, 1, 8'h02, 8'h12, 16'd2));
    tbl.push_back(mk(1, 0, 8'h22, 0, 8'h00, 8'hFF, 1, 8'h20, 8'h13, 16'd3));
    // No enabled channel in round-robin mode: nothing accepted.
    tbl.push_back(mk(1, 0, 8'h00, 1, 8'h55, 8'hFF, 0, 8'h00, 8'h00, 16'd4));
    tbl.push_back(mk(1, 0, 8'h00, 1, 8'h56, 8'hFF, 0, 8'h00, 8'h00, 16'd4));

    rst_n = 0; mode = 0; dest = 0; chan_en = 8'h00;
    in_valid = 0; in_data = 8'h00; out_ready = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk("rst_out_valid", {24'd0, out_valid}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    chk("rst_cur_sel", {29'd0, cur_sel}, 32'd0);
    chk("rst_beat_cnt", {16'd0, beat_cnt}, 32'd0);
    chk("rst_drop_cnt", {24'd0, drop_cnt}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);

    foreach (tbl[i]) begin
      apply(tbl[i].rst, tbl[i].md, 3'd0, tbl[i].en, tbl[i].vld, tbl[i].dat, tbl[i].rdy);
      chk($sformatf("tbl%0d_in_ready", i), {31'd0, in_ready}, {31'd0, tbl[i].exp_rdy});
      chk($sformatf("tbl%0d_out_valid", i), {24'd0, out_valid}, {24'd0, tbl[i].exp_ov});
      if (tbl[i].exp_ov != 8'h00)
        chk($sformatf("tbl%0d_out_data", i), {24'd0, out_data}, {24'd0, tbl[i].exp_data});
      chk($sformatf("tbl%0d_beat_cnt", i), {16'd0, beat_cnt}, {16'd0, tbl[i].exp_beat});
      advance();
    end

    // Directed beat to channel 3 stalled by its consumer for 4 cycles.
    apply(1, 1, 3'd3, 8'hFF, 1, 8'hA5, 8'hF7);
    advance();
    held_data    = 8'hA5;
    beats_before = beat_cnt;
    for (int k = 0; k < 4; k++) begin
      apply(1, 1, 3'd3, 8'hFF, 1, 8'(8'hB0 + k), 8'hF7);
      chk("stall_out_valid", {24'd0, out_valid}, 32'h08);
      chk("stall_out_data", {24'd0, out_data}, {24'd0, held_data});
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      advance();
    end
    apply(1, 1, 3'd3, 8'hFF, 0, 8'h00, 8'hFF);
    advance();
    apply(1, 1, 3'd3, 8'hFF, 0, 8'h00, 8'hFF);
    chk("release_beat_cnt", {16'd0, beat_cnt}, {16'd0, beats_before + 16'd1});
    chk("release_out_valid", {24'd0, out_valid}, 32'd0);
    advance();

    // Directed to a disabled channel: every beat dropped, count saturates.
    for (int k = 0; k < 300; k++) begin
      apply(1, 1, 3'd6, 8'hBF, 1, 8'(k), 8'hFF);
      advance();
    end
    apply(1, 1, 3'd6, 8'hBF, 0, 8'h00, 8'hFF);
    chk("drop_sat", {24'd0, drop_cnt}, 32'd255);
    chk("drop_no_valid", {24'd0, out_valid}, 32'd0);
    advance();

    // Reset while holding a beat: beat discarded, next grant to channel 0.
    apply(1, 0, 3'd0, 8'hFF, 1, 8'h66, 8'h00);
    advance();
    apply(0, 0, 3'd0, 8'hFF, 0, 8'h00, 8'h00);
    advance();
    apply(1, 0, 3'd0, 8'hFF, 1, 8'h77, 8'hFF);
    chk("hrst_out_valid", {24'd0, out_valid}, 32'd0);
    chk("hrst_beat_cnt", {16'd0, beat_cnt}, 32'd0);
    chk("hrst_drop_cnt", {24'd0, drop_cnt}, 32'd0);
    advance();
    apply(1, 0, 3'd0, 8'hFF, 0, 8'h00, 8'h00);
    chk("hrst_grant", {24'd0, out_valid}, 32'h01);
    chk("hrst_data", {24'd0, out_data}, 32'h77);
    advance();

    // Randomized traffic against the reference model.
    for (int k = 0; k < 3000; k++) begin
      logic [7:0] en;
      en = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
      apply(($urandom_range(0, 99) != 0), 1'($urandom), 3'($urandom), en,
            ($urandom_range(0, 3) != 0), 8'($urandom),
            ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom));
      advance();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
